// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/twos_neg.sv
// Combinational conditional two's-complement negate.
module twos_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = neg ? (~in + WIDTH'(1)) : in;
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: signed/unsigned quotient (Lo) and remainder (Hi),
// one quotient bit per cycle with a start/busy/done handshake.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divStart,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CntW-1:0]  cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             divzero_q;

    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;

    assign b_zero = (B == '0);
    assign a_neg  = isSigned & A[WIDTH-1];
    assign b_neg  = isSigned & B[WIDTH-1];

    twos_neg #(.WIDTH(WIDTH)) u_abs_a (.in(A), .neg(a_neg), .out(abs_a));
    twos_neg #(.WIDTH(WIDTH)) u_abs_b (.in(B), .neg(b_neg), .out(abs_b));

    twos_neg #(.WIDTH(WIDTH)) u_fix_lo (.in(quo_q), .neg(qneg_q), .out(lo_fix));
    twos_neg #(.WIDTH(WIDTH)) u_fix_hi (.in(rem_q[WIDTH-1:0]), .neg(rneg_q), .out(hi_fix));

    // Partial remainder is kept one bit wider so a shifted value up to
    // 2^(WIDTH+1)-1 compares correctly against divisors up to 2^WIDTH-1.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {2'b00, dvs_q};
        ge       = ~diff[WIDTH+1];
        rem_next = ge ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (divStart) begin
                    state_d = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        DivZero = divzero_q;
        Hi      = hi_q;
        Lo      = lo_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (divStart) begin
                        divzero_q <= b_zero;
                        if (!b_zero) begin
                            dvd_q  <= abs_a;
                            dvs_q  <= abs_b;
                            rneg_q <= a_neg;
                            qneg_q <= a_neg ^ b_neg;
                            cnt_q  <= CntW'(WIDTH);
                            rem_q  <= '0;
                            quo_q  <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CntW'(1);
                end
                FIX: begin
                    lo_q <= lo_fix;
                    hi_q <= hi_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at WIDTH 32 and 8 against an arithmetic model.
module tb_div_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        start32, sgn32, busy32, done32, dz32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, sgn8, busy8, done8, dz8;
    logic [7:0]  a8, b8, hi8, lo8;

    logic [31:0] mhi32, mlo32;
    logic [7:0]  mhi8, mlo8;

    div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .divStart(start32), .isSigned(sgn32),
        .A(a32), .B(b32), .busy(busy32), .done(done32), .DivZero(dz32),
        .Hi(hi32), .Lo(lo32)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .divStart(start8), .isSigned(sgn8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .DivZero(dz8),
        .Hi(hi8), .Lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division on w-bit operands using 64-bit host arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input int w,
                                  input bit s, output logic [31:0] q, output logic [31:0] r);
        longint m, sa, sb, lq, lr;
        m  = longint'(1) << w;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - m;
        if (s && b[w-1]) sb = sb - m;
        lq = sa / sb;
        lr = sa % sb;
        q  = 32'(lq & (m - 1));
        r  = 32'(lr & (m - 1));
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output int lat);
        @(negedge clk);
        a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sgn32 = ~s;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done32) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            if (done8) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do32(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input string tag);
        int lat;
        logic [31:0] q, r;
        run32(a, b, s, lat);
        if (b == 32'd0) begin
            check({tag, " latency"}, 64'(lat), 64'd1);
            check({tag, " divzero"}, 64'(dz32), 64'd1);
        end else begin
            model(a, b, 32, s, q, r);
            mlo32 = q;
            mhi32 = r;
            check({tag, " latency"}, 64'(lat), 64'd34);
            check({tag, " divzero"}, 64'(dz32), 64'd0);
        end
        check({tag, " lo"}, 64'(lo32), 64'(mlo32));
        check({tag, " hi"}, 64'(hi32), 64'(mhi32));
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b, input bit s, input string tag);
        int lat;
        logic [31:0] q, r;
        run8(a, b, s, lat);
        if (b == 8'd0) begin
            check({tag, " latency"}, 64'(lat), 64'd1);
            check({tag, " divzero"}, 64'(dz8), 64'd1);
        end else begin
            model({24'd0, a}, {24'd0, b}, 8, s, q, r);
            mlo8 = q[7:0];
            mhi8 = r[7:0];
            check({tag, " latency"}, 64'(lat), 64'd10);
            check({tag, " divzero"}, 64'(dz8), 64'd0);
        end
        check({tag, " lo"}, 64'(lo8), 64'(mlo8));
        check({tag, " hi"}, 64'(hi8), 64'(mhi8));
    endtask

    initial begin
        int nd, first, second, b36, sel;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;

        reset = 1'b1;
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
        start8 = 1'b1;  sgn8 = 1'b0;  a8 = 8'd100;   b8 = 8'd7;
        mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset divzero", 64'(dz32), 64'd0);
        check("reset hi", 64'(hi32), 64'd0);
        check("reset lo", 64'(lo32), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        start32 = 1'b0; start8 = 1'b0;
        reset = 1'b0;

        do32(32'h00000007, 32'hFFFFFFFE, 1'b1, "7/-2");
        check("7/-2 lo const", 64'(lo32), 64'h00000000FFFFFFFD);
        check("7/-2 hi const", 64'(hi32), 64'h0000000000000001);
        do32(32'hFFFFFFF9, 32'h00000002, 1'b1, "-7/2");
        check("-7/2 hi const", 64'(hi32), 64'h00000000FFFFFFFF);
        do32(32'hFFFFFFF9, 32'h00000002, 1'b0, "-7/2 unsigned");
        check("-7/2u lo const", 64'(lo32), 64'h000000007FFFFFFC);
        do32(32'hFFFFFFFF, 32'h00000010, 1'b0, "ffffffff/16");
        check("ffffffff/16 lo const", 64'(lo32), 64'h000000000FFFFFFF);
        do32(32'h80000000, 32'hFFFFFFFF, 1'b1, "min/-1");
        check("min/-1 lo const", 64'(lo32), 64'h0000000080000000);
        check("min/-1 hi const", 64'(hi32), 64'd0);
        do32(32'hFFFFFFFF, 32'h80000001, 1'b0, "wide remainder");

        do32(32'd100, 32'd7, 1'b0, "100/7");
        do32(32'd100, 32'd0, 1'b0, "100/0");
        check("100/0 hi const", 64'(hi32), 64'd2);
        check("100/0 lo const", 64'(lo32), 64'd14);
        do32(32'd9, 32'd3, 1'b1, "9/3 after div0");

        // Starts during CALC, FIX and DONE are ignored; one right after done is taken.
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        nd = 0; first = -1; second = -1; b36 = 0;
        for (int k = 1; k <= 80; k++) begin
            start32 = (k == 5 || k == 33 || k == 34 || k == 35);
            if (k == 5 || k == 33 || k == 34) begin
                a32 = $urandom; b32 = $urandom | 32'd1;
            end
            if (k == 35) begin
                a32 = 32'd50; b32 = 32'd5; sgn32 = 1'b0;
            end
            if (done32) begin
                nd++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 34) begin
                check("b2b first lo", 64'(lo32), 64'd14);
                check("b2b first hi", 64'(hi32), 64'd2);
            end
            if (k == 36) b36 = int'(busy32);
            @(negedge clk);
        end
        start32 = 1'b0;
        check("b2b done count", 64'(nd), 64'd2);
        check("b2b first done", 64'(first), 64'd34);
        check("b2b second done", 64'(second), 64'd69);
        check("b2b accepted busy", 64'(b36), 64'd1);
        check("b2b second lo", 64'(lo32), 64'd10);
        check("b2b second hi", 64'(hi32), 64'd0);

        // Reset in the middle of CALC.
        a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy", 64'(busy32), 64'd0);
        check("midreset done", 64'(done32), 64'd0);
        check("midreset hi", 64'(hi32), 64'd0);
        check("midreset lo", 64'(lo32), 64'd0);
        check("midreset divzero", 64'(dz32), 64'd0);
        reset = 1'b0;
        mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
        do32(32'd100, 32'd7, 1'b0, "post-reset 100/7");
        check("post-reset lo const", 64'(lo32), 64'd14);

        do8(8'h80, 8'hFF, 1'b1, "w8 min/-1");
        check("w8 min/-1 lo const", 64'(lo8), 64'h80);
        check("w8 min/-1 hi const", 64'(hi8), 64'h00);

        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel < 3) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) rb = 32'hFFFFFFFF;
            else if (sel == 4) ra = 32'h80000000;
            do32(ra, rb, 1'($urandom_range(0, 1)), "rand32");
        end
        for (int i = 0; i < 20; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            if (i % 7 == 0) rb8 = 8'd0;
            do8(ra8, rb8, 1'($urandom_range(0, 1)), "rand8");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
